// File: rtl/tipi_4bit_bus_master_if.sv
// Host-side request/response and bus strobe signals of the TIPI 4-bit bus master.
// The nibble data lines stay a plain inout port on the master so the tristate resolves at the pins.
interface tipi_4bit_bus_master_if;
  logic       start;
  logic [1:0] reg_sel;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       bus_clk;
  logic       bus_reset;

  modport master (
    input  start, reg_sel, wdata,
    output rdata, busy, done, bus_clk, bus_reset
  );

  modport slave (
    output start, reg_sel, wdata,
    input  rdata, busy, done, bus_clk, bus_reset
  );
endinterface

// File: rtl/tipi_4bit_bus_master.sv
// Pi-side initiator for the TIPI nibble bus: select nibble, then two data nibbles (high first).
// Bus outputs are registered from the next-state decode so they stay glitch-free and phase-aligned.
module tipi_4bit_bus_master #(
  parameter int HALF_PERIOD = 2,
  parameter bit RESET_EACH  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  tipi_4bit_bus_master_if.master        mif,
  inout  wire  [3:0]                    bus_data
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_GAP, S_SSET, S_SHI, S_SLO, S_DSET, S_DHI, S_DLO, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          phase_end;
  logic          accept;
  logic          nib, nib_nxt;
  logic [1:0]    sel_q, sel_nxt;
  logic [7:0]    wdata_q, wdata_nxt;
  logic [3:0]    shift_hi;
  logic [7:0]    rdata_q;
  logic          bus_clk_q, bus_clk_nxt;
  logic          bus_reset_q, bus_reset_nxt;
  logic          oe_q, oe_nxt;
  logic [3:0]    dout_q, dout_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          rd_sample;

  assign phase_end = (cnt == CW'(HALF_PERIOD - 1));
  assign accept    = (state == S_IDLE) && mif.start;
  assign sel_nxt   = accept ? mif.reg_sel : sel_q;
  assign wdata_nxt = accept ? mif.wdata   : wdata_q;
  assign rd_sample = (state == S_DLO) && phase_end && !sel_q[1];

  always_comb begin
    state_nxt = state;
    nib_nxt   = nib;
    unique case (state)
      S_IDLE: begin
        nib_nxt = 1'b0;
        if (mif.start) state_nxt = RESET_EACH ? S_RST : S_SSET;
      end
      S_RST:  if (phase_end) state_nxt = S_GAP;
      S_GAP:  if (phase_end) state_nxt = S_SSET;
      S_SSET: if (phase_end) state_nxt = S_SHI;
      S_SHI:  if (phase_end) state_nxt = S_SLO;
      S_SLO:  if (phase_end) state_nxt = S_DSET;
      S_DSET: if (phase_end) state_nxt = S_DHI;
      S_DHI:  if (phase_end) state_nxt = S_DLO;
      S_DLO: begin
        if (phase_end) begin
          if (nib) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DSET;
            nib_nxt   = 1'b1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Bus-side outputs for the state being entered
    bus_clk_nxt   = (state_nxt == S_SHI) || (state_nxt == S_DHI);
    bus_reset_nxt = (state_nxt == S_RST);
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    oe_nxt        = 1'b0;
    dout_nxt      = dout_q;
    unique case (state_nxt)
      S_SSET, S_SHI, S_SLO: begin
        oe_nxt   = 1'b1;
        dout_nxt = {2'b00, sel_nxt};
      end
      S_DSET, S_DHI, S_DLO: begin
        if (sel_nxt[1]) begin
          oe_nxt   = 1'b1;
          dout_nxt = nib_nxt ? wdata_nxt[3:0] : wdata_nxt[7:4];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      nib         <= 1'b0;
      bus_clk_q   <= 1'b0;
      bus_reset_q <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state || state == S_IDLE) ? '0 : cnt + 1'b1;
      nib         <= nib_nxt;
      bus_clk_q   <= bus_clk_nxt;
      bus_reset_q <= bus_reset_nxt;
      oe_q        <= oe_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      if (rd_sample && nib) rdata_q <= {shift_hi, bus_data};
    end
  end

  // Datapath holding registers carry no reset
  always_ff @(posedge clk) begin
    sel_q   <= sel_nxt;
    wdata_q <= wdata_nxt;
    dout_q  <= dout_nxt;
    if (rd_sample && !nib) shift_hi <= bus_data;
  end

  assign bus_data      = oe_q ? dout_q : 4'bz;
  assign mif.rdata     = rdata_q;
  assign mif.busy      = busy_q;
  assign mif.done      = done_q;
  assign mif.bus_clk   = bus_clk_q;
  assign mif.bus_reset = bus_reset_q;

endmodule

// File: tb/tb_tipi_4bit_bus_master.sv
// Directed bench for tipi_4bit_bus_master with a behavioural TI-side responder on each bus.
// Two masters: HALF_PERIOD=2/RESET_EACH=1 and HALF_PERIOD=1/RESET_EACH=0.
module tb_tipi_4bit_bus_master;

  logic clk;
  logic reset;
  logic [7:0] td, tc;

  tipi_4bit_bus_master_if mif0 ();
  tipi_4bit_bus_master_if mif1 ();
  tri1 [3:0] bd0;
  tri1 [3:0] bd1;

  tipi_4bit_bus_master #(.HALF_PERIOD(2), .RESET_EACH(1'b1)) dut0 (
    .clk(clk), .reset(reset), .mif(mif0), .bus_data(bd0)
  );
  tipi_4bit_bus_master #(.HALF_PERIOD(1), .RESET_EACH(1'b0)) dut1 (
    .clk(clk), .reset(reset), .mif(mif1), .bus_data(bd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: rise 1 captures select, rise 2/3 move data nibbles
  typedef struct packed {
    logic       bclk_d;
    logic [1:0] cnt;
    logic [1:0] sel;
    logic [3:0] hi;
    logic       oe;
    logic [3:0] dout;
    logic [7:0] rd;
    logic [7:0] rc;
  } rsp_t;

  rsp_t r0, r1;

  function automatic rsp_t rsp_step(input rsp_t s, input logic clr, input logic bclk,
                                    input logic brst, input logic [3:0] d);
    rsp_t n;
    n = s;
    n.bclk_d = bclk;
    if (clr || brst) begin
      n.cnt = 2'd0;
      n.oe  = 1'b0;
    end else if (bclk && !s.bclk_d) begin
      case (s.cnt)
        2'd0: begin
          n.sel = d[1:0];
          n.cnt = 2'd1;
        end
        2'd1: begin
          if (s.sel[1]) n.hi = d;
          else begin
            n.oe   = 1'b1;
            n.dout = s.sel[0] ? tc[7:4] : td[7:4];
          end
          n.cnt = 2'd2;
        end
        2'd2: begin
          if (!s.sel[1]) n.dout = s.sel[0] ? tc[3:0] : td[3:0];
          else if (s.sel[0]) n.rc = {s.hi, d};
          else n.rd = {s.hi, d};
          n.cnt = 2'd3;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) r0 <= rsp_step(r0, reset || mif0.done, mif0.bus_clk, mif0.bus_reset, bd0);
  always @(posedge clk) r1 <= rsp_step(r1, reset || mif1.done, mif1.bus_clk, mif1.bus_reset, bd1);

  assign bd0 = r0.oe ? r0.dout : 4'bz;
  assign bd1 = r1.oe ? r1.dout : 4'bz;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle observations of the last transaction, indexed by cycle after start sampling
  logic [3:0] bd_log [64];
  logic       busy_log [64];
  logic [3:0] rise_log [4];
  int         nr, rst_total, rst_before;

  task automatic drv(input int u, input logic st, input logic [1:0] sel, input logic [7:0] wd);
    if (u == 0) begin
      mif0.start = st; mif0.reg_sel = sel; mif0.wdata = wd;
    end else begin
      mif1.start = st; mif1.reg_sel = sel; mif1.wdata = wd;
    end
  endtask

  task automatic txn(input int u, input logic [1:0] sel, input logic [7:0] wd,
                     input int ghost, output int lat);
    logic pbc, bc, br, dn;
    logic [3:0] bd;
    drv(u, 1'b1, sel, wd);
    lat = 0; nr = 0; rst_total = 0; rst_before = 0;
    pbc = (u == 0) ? mif0.bus_clk : mif1.bus_clk;
    for (int c = 1; c < 64 && lat == 0; c++) begin
      @(negedge clk);
      drv(u, (c == ghost), 2'd2, 8'h00);
      bc = (u == 0) ? mif0.bus_clk   : mif1.bus_clk;
      br = (u == 0) ? mif0.bus_reset : mif1.bus_reset;
      dn = (u == 0) ? mif0.done      : mif1.done;
      bd = (u == 0) ? bd0 : bd1;
      bd_log[c]   = bd;
      busy_log[c] = (u == 0) ? mif0.busy : mif1.busy;
      if (bc && !pbc) begin
        if (nr < 4) rise_log[nr] = bd;
        nr++;
      end
      if (br) begin
        rst_total++;
        if (nr == 0) rst_before++;
      end
      if (dn) lat = c;
      pbc = bc;
    end
    drv(u, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic idle_watch(input int u, input int n, output int dn);
    dn = 0;
    repeat (n) begin
      @(negedge clk);
      if ((u == 0) ? mif0.done : mif1.done) dn++;
    end
  endtask

  int lat, dn;

  initial begin
    reset = 1'b1;
    td = 8'hA5;
    tc = 8'h5A;
    drv(0, 1'b0, 2'd0, 8'h00);
    drv(1, 1'b0, 2'd0, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(mif0.busy), 32'd0);
    check("rst_done",    32'(mif0.done), 32'd0);
    check("rst_bus_clk", 32'(mif0.bus_clk), 32'd0);
    check("rst_bus_rst", 32'(mif0.bus_reset), 32'd0);
    check("rst_rdata",   32'(mif0.rdata), 32'h00);
    check("rst_bus_z",   32'(bd0), 32'hF);
    check("rst1_busy",   32'(mif1.busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Read TD
    txn(0, 2'd0, 8'h00, 0, lat);
    check("td_latency", 32'(lat), 32'd23);
    check("td_rdata",   32'(mif0.rdata), 32'hA5);
    check("td_rises",   32'(nr), 32'd3);
    check("td_sel_nib", 32'(rise_log[0]), 32'h0);
    check("td_busy",    32'(busy_log[1]), 32'd1);
    check("td_z_set0a", 32'(bd_log[11]), 32'hF);
    check("td_z_set0b", 32'(bd_log[12]), 32'hF);
    check("td_z_hi0",   32'(bd_log[13]), 32'hF);
    check("td_drv_lo0", 32'(bd_log[16]), 32'hA);
    check("td_drv_lo1", 32'(bd_log[22]), 32'h5);
    @(negedge clk);
    check("td_done_1cyc", 32'(mif0.done), 32'd0);
    check("td_idle_busy", 32'(mif0.busy), 32'd0);
    repeat (2) @(negedge clk);

    // Read TC
    txn(0, 2'd1, 8'h00, 0, lat);
    check("tc_latency",   32'(lat), 32'd23);
    check("tc_rdata",     32'(mif0.rdata), 32'h5A);
    check("tc_sel_nib",   32'(rise_log[0]), 32'h1);
    check("tc_rst_len",   32'(rst_total), 32'd2);
    check("tc_rst_first", 32'(rst_before), 32'd2);
    repeat (3) @(negedge clk);

    // Write RD
    txn(0, 2'd2, 8'hA5, 0, lat);
    check("rd_latency", 32'(lat), 32'd23);
    check("rd_seq",     32'({rise_log[0], rise_log[1], rise_log[2]}), 32'h2A5);
    check("rd_resp",    32'(r0.rd), 32'hA5);
    check("rd_rdata",   32'(mif0.rdata), 32'h5A);
    repeat (2) @(negedge clk);

    // Write RC with an ignored start while busy, then a back-to-back read
    tc = 8'h96;
    txn(0, 2'd3, 8'h5A, 5, lat);
    check("rc_latency", 32'(lat), 32'd23);
    check("rc_seq",     32'({rise_log[0], rise_log[1], rise_log[2]}), 32'h35A);
    check("rc_resp",    32'(r0.rc), 32'h5A);
    @(negedge clk);
    check("b2b_idle", 32'(mif0.busy), 32'd0);
    txn(0, 2'd1, 8'h00, 0, lat);
    check("b2b_latency", 32'(lat), 32'd23);
    check("b2b_rdata",   32'(mif0.rdata), 32'h96);
    idle_watch(0, 30, dn);
    check("ghost_done",  32'(dn), 32'd0);
    check("ghost_rd",    32'(r0.rd), 32'hA5);

    // Reset during nibble-0 HI of a read
    drv(0, 1'b1, 2'd0, 8'h00);
    @(negedge clk);
    drv(0, 1'b0, 2'd0, 8'h00);
    repeat (12) @(negedge clk);
    check("mid_hi_clk", 32'(mif0.bus_clk), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_bus_z",   32'(bd0), 32'hF);
    check("mid_bus_clk", 32'(mif0.bus_clk), 32'd0);
    check("mid_busy",    32'(mif0.busy), 32'd0);
    check("mid_done",    32'(mif0.done), 32'd0);
    check("mid_rdata",   32'(mif0.rdata), 32'h00);
    idle_watch(0, 30, dn);
    check("mid_no_done", 32'(dn), 32'd0);
    td = 8'h3C;
    txn(0, 2'd0, 8'h00, 0, lat);
    check("post_latency", 32'(lat), 32'd23);
    check("post_rdata",   32'(mif0.rdata), 32'h3C);
    repeat (2) @(negedge clk);

    // HALF_PERIOD=1, no bus reset
    tc = 8'hC3;
    txn(1, 2'd1, 8'h00, 0, lat);
    check("p_latency", 32'(lat), 32'd10);
    check("p_rdata",   32'(mif1.rdata), 32'hC3);
    check("p_rises",   32'(nr), 32'd3);
    check("p_no_rst",  32'(rst_total), 32'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
